// File: rtl/periph_bus_arbiter_if.sv
// Peripheral register bus bundle: two request ports plus the shared slave side.
// The arbiter takes the slave modport; masters and slave models take master.
interface periph_bus_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              m0_req_i;
  logic              m0_we_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [31:0]       m0_wdata_i;
  logic [31:0]       m0_rdata_o;
  logic              m0_ack_o;

  logic              m1_req_i;
  logic              m1_we_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [31:0]       m1_wdata_i;
  logic [31:0]       m1_rdata_o;
  logic              m1_ack_o;

  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [31:0]       wr_data_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [31:0]       rd_data_i;
  logic              busy_o;

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m0_rdata_o, m0_ack_o,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output m1_rdata_o, m1_ack_o,
    output wr_en_o, wr_addr_o, wr_data_o, rd_addr_o,
    input  rd_data_i,
    output busy_o
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m0_rdata_o, m0_ack_o,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  m1_rdata_o, m1_ack_o,
    input  wr_en_o, wr_addr_o, wr_data_o, rd_addr_o,
    output rd_data_i,
    input  busy_o
  );
endinterface

// File: rtl/periph_bus_arbiter.sv
// Two-master / one-slave peripheral bus arbiter, four-cycle transfers,
// round-robin or fixed priority, registered outputs throughout.
module periph_bus_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int ADDR_W     = 32
) (
  input  logic sys_clk,
  input  logic sys_reset,
  periph_bus_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        r_state;
  logic              r_last;
  logic              r_gnt;
  logic              r_we;
  logic              r_busy;
  logic              r_m0_ack;
  logic              r_m1_ack;
  logic [31:0]       r_m0_rdata;
  logic [31:0]       r_m1_rdata;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic [ADDR_W-1:0] r_rd_addr;

  logic              w_any;
  logic              w_win;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;

  assign w_any = bus.m0_req_i | bus.m1_req_i;

  // r_last resets to 1 so master 0 takes the first tie
  always_comb begin
    w_win = bus.m1_req_i;
    if (bus.m0_req_i && bus.m1_req_i)
      w_win = FIXED_PRIO ? 1'b0 : ~r_last;
  end

  assign w_we    = w_win ? bus.m1_we_i    : bus.m0_we_i;
  assign w_addr  = w_win ? bus.m1_addr_i  : bus.m0_addr_i;
  assign w_wdata = w_win ? bus.m1_wdata_i : bus.m0_wdata_i;

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_gnt      <= 1'b0;
      r_we       <= 1'b0;
      r_busy     <= 1'b0;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_rd_addr  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_ACCESS;
            r_busy  <= 1'b1;
            r_gnt   <= w_win;
            r_last  <= w_win;
            r_we    <= w_we;
            if (w_we) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= w_addr;
              r_wr_data <= w_wdata;
            end else begin
              r_rd_addr <= w_addr;
            end
          end
        end
        S_ACCESS: begin
          r_wr_en <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // slave data is valid now, one cycle after rd_addr
          if (!r_we) begin
            if (r_gnt) r_m1_rdata <= bus.rd_data_i;
            else       r_m0_rdata <= bus.rd_data_i;
          end
          if (r_gnt) r_m1_ack <= 1'b1;
          else       r_m0_ack <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_m0_ack <= 1'b0;
          r_m1_ack <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.m0_ack_o   = r_m0_ack;
  assign bus.m1_ack_o   = r_m1_ack;
  assign bus.m0_rdata_o = r_m0_rdata;
  assign bus.m1_rdata_o = r_m1_rdata;
  assign bus.wr_en_o    = r_wr_en;
  assign bus.wr_addr_o  = r_wr_addr;
  assign bus.wr_data_o  = r_wr_data;
  assign bus.rd_addr_o  = r_rd_addr;
  assign bus.busy_o     = r_busy;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter: round-robin and fixed-priority instances
// run side by side against a transaction-level timeline model.
module tb_periph_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  periph_bus_arbiter_if bus0 ();
  periph_bus_arbiter_if bus1 ();

  periph_bus_arbiter #(.FIXED_PRIO(1'b0), .ADDR_W(32)) u_rr (
    .sys_clk(clk), .sys_reset(rst), .bus(bus0.slave)
  );
  periph_bus_arbiter #(.FIXED_PRIO(1'b1), .ADDR_W(32)) u_fp (
    .sys_clk(clk), .sys_reset(rst), .bus(bus1.slave)
  );

  // GPIO-style register file slaves with one-cycle registered read
  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];
  always @(posedge clk) begin
    if (bus0.wr_en_o) mem0[bus0.wr_addr_o[5:2]] <= bus0.wr_data_o;
    bus0.rd_data_i <= mem0[bus0.rd_addr_o[5:2]];
  end
  always @(posedge clk) begin
    if (bus1.wr_en_o) mem1[bus1.wr_addr_o[5:2]] <= bus1.wr_data_o;
    bus1.rd_data_i <= mem1[bus1.rd_addr_o[5:2]];
  end

  int n_vec;
  int n_err;
  int cyc;
  int mode;
  bit rst_drv;

  bit          pend   [2][2];
  bit          cwe    [2][2];
  logic [31:0] caddr  [2][2];
  logic [31:0] cwdata [2][2];
  int          nack   [2][2];

  int          t_start [2];
  bit          t_win   [2];
  bit          t_we    [2];
  logic [31:0] t_addr  [2];
  logic [31:0] t_wdata [2];
  logic [31:0] t_rdata [2];
  bit          last    [2];
  int          freec   [2];
  logic [31:0] e_rdata [2][2];
  logic [31:0] e_wr_addr [2];
  logic [31:0] e_wr_data [2];
  logic [31:0] e_rd_addr [2];
  logic [31:0] mmem [2][16];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset(input int i);
    t_start[i] = -100;
    last[i]    = 1'b1;
    freec[i]   = cyc + 1;
    e_rdata[i][0] = '0;
    e_rdata[i][1] = '0;
    e_wr_addr[i]  = '0;
    e_wr_data[i]  = '0;
    e_rd_addr[i]  = '0;
    pend[i][0] = 1'b0;
    pend[i][1] = 1'b0;
  endtask

  task automatic grant(input int i);
    bit w;
    logic [3:0] idx;
    if (pend[i][0] && pend[i][1])
      w = (i == 1) ? 1'b0 : ~last[i];
    else
      w = pend[i][1];
    t_start[i] = cyc;
    t_win[i]   = w;
    t_we[i]    = cwe[i][w];
    t_addr[i]  = caddr[i][w];
    t_wdata[i] = cwdata[i][w];
    idx = caddr[i][w][5:2];
    if (cwe[i][w]) mmem[i][idx] = cwdata[i][w];
    else           t_rdata[i]   = mmem[i][idx];
    last[i]  = w;
    freec[i] = cyc + 4;
  endtask

  task automatic new_cmd(input int i, input int m);
    bit go;
    go = (mode == 2) || (mode == 1 && $urandom_range(0, 2) == 0);
    if (go) begin
      pend[i][m]   = 1'b1;
      cwe[i][m]    = 1'($urandom_range(0, 1));
      caddr[i][m]  = 32'($urandom_range(0, 15)) << 2;
      cwdata[i][m] = $urandom;
    end
  endtask

  task automatic issue(input int m, input bit w, input logic [31:0] a,
                       input logic [31:0] d);
    for (int i = 0; i < 2; i++) begin
      pend[i][m]   = 1'b1;
      cwe[i][m]    = w;
      caddr[i][m]  = a;
      cwdata[i][m] = d;
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      logic a0, a1, wen, bz;
      logic [31:0] r0, r1, wa, wd, ra;
      bit hit1, hit3, ea0, ea1, ewe, ebz;
      if (i == 0) begin
        a0 = bus0.m0_ack_o;   a1 = bus0.m1_ack_o;
        r0 = bus0.m0_rdata_o; r1 = bus0.m1_rdata_o;
        wen = bus0.wr_en_o;   wa = bus0.wr_addr_o;
        wd = bus0.wr_data_o;  ra = bus0.rd_addr_o;
        bz = bus0.busy_o;
      end else begin
        a0 = bus1.m0_ack_o;   a1 = bus1.m1_ack_o;
        r0 = bus1.m0_rdata_o; r1 = bus1.m1_rdata_o;
        wen = bus1.wr_en_o;   wa = bus1.wr_addr_o;
        wd = bus1.wr_data_o;  ra = bus1.rd_addr_o;
        bz = bus1.busy_o;
      end
      hit1 = (cyc == t_start[i] + 1);
      hit3 = (cyc == t_start[i] + 3);
      if (hit1) begin
        if (t_we[i]) begin
          e_wr_addr[i] = t_addr[i];
          e_wr_data[i] = t_wdata[i];
        end else begin
          e_rd_addr[i] = t_addr[i];
        end
      end
      if (hit3 && !t_we[i]) e_rdata[i][t_win[i]] = t_rdata[i];
      ea0 = hit3 && !t_win[i];
      ea1 = hit3 && t_win[i];
      ewe = hit1 && t_we[i];
      ebz = (cyc > t_start[i]) && (cyc <= t_start[i] + 3);
      chk($sformatf("u%0d m0_ack", i), 32'(a0), 32'(ea0));
      chk($sformatf("u%0d m1_ack", i), 32'(a1), 32'(ea1));
      chk($sformatf("u%0d m0_rdata", i), r0, e_rdata[i][0]);
      chk($sformatf("u%0d m1_rdata", i), r1, e_rdata[i][1]);
      chk($sformatf("u%0d wr_en", i), 32'(wen), 32'(ewe));
      chk($sformatf("u%0d wr_addr", i), wa, e_wr_addr[i]);
      chk($sformatf("u%0d wr_data", i), wd, e_wr_data[i]);
      chk($sformatf("u%0d rd_addr", i), ra, e_rd_addr[i]);
      chk($sformatf("u%0d busy", i), 32'(bz), 32'(ebz));
      if (a0 === 1'b1) nack[i][0]++;
      if (a1 === 1'b1) nack[i][1]++;
    end
  endtask

  task automatic update_and_drive();
    for (int i = 0; i < 2; i++)
      for (int m = 0; m < 2; m++) begin
        if (cyc == t_start[i] + 3 && int'(t_win[i]) == m)
          pend[i][m] = 1'b0;
        if (!pend[i][m]) new_cmd(i, m);
      end
    rst = rst_drv;
    bus0.m0_req_i = pend[0][0];   bus0.m1_req_i = pend[0][1];
    bus0.m0_we_i  = cwe[0][0];    bus0.m1_we_i  = cwe[0][1];
    bus0.m0_addr_i  = caddr[0][0];  bus0.m1_addr_i  = caddr[0][1];
    bus0.m0_wdata_i = cwdata[0][0]; bus0.m1_wdata_i = cwdata[0][1];
    bus1.m0_req_i = pend[1][0];   bus1.m1_req_i = pend[1][1];
    bus1.m0_we_i  = cwe[1][0];    bus1.m1_we_i  = cwe[1][1];
    bus1.m0_addr_i  = caddr[1][0];  bus1.m1_addr_i  = caddr[1][1];
    bus1.m0_wdata_i = cwdata[1][0]; bus1.m1_wdata_i = cwdata[1][1];
    for (int i = 0; i < 2; i++) begin
      if (rst_drv) model_reset(i);
      else if (cyc >= freec[i] && (pend[i][0] || pend[i][1])) grant(i);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    update_and_drive();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    mode  = 0;
    cyc   = 0;
    for (int i = 0; i < 2; i++)
      for (int m = 0; m < 2; m++) begin
        cwe[i][m] = 1'b0;
        caddr[i][m] = '0;
        cwdata[i][m] = '0;
        nack[i][m] = 0;
      end
    for (int i = 0; i < 2; i++) model_reset(i);
    rst_drv = 1'b1;
    update_and_drive();
    repeat (2) @(posedge clk);
    #1;
    rst_drv = 1'b0;
    for (int i = 0; i < 2; i++) model_reset(i);
    check_outputs();
    update_and_drive();

    // fill every slave register through master 0
    for (int k = 0; k < 16; k++) begin
      logic [31:0] d;
      d = (k == 1) ? 32'h5 : (k == 2) ? 32'hA5 : $urandom;
      issue(0, 1'b1, 32'(k) << 2, d);
      repeat (4) step();
    end

    issue(1, 1'b0, 32'h8, 32'h0);
    repeat (4) step();
    chk("u0 m1 read A5", bus0.m1_rdata_o, 32'hA5);
    chk("u1 m1 read A5", bus1.m1_rdata_o, 32'hA5);

    issue(0, 1'b1, 32'h4, 32'h3);
    repeat (4) step();
    issue(0, 1'b0, 32'h4, 32'h0);
    repeat (4) step();
    chk("u0 readback", bus0.m0_rdata_o, 32'h3);
    chk("u1 readback", bus1.m0_rdata_o, 32'h3);

    rst_drv = 1'b1;
    step();
    rst_drv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      nack[i][0] = 0;
      nack[i][1] = 0;
    end
    mode = 2;
    repeat (16) step();
    chk("u0 rr m0 acks", 32'(nack[0][0]), 32'd2);
    chk("u0 rr m1 acks", 32'(nack[0][1]), 32'd2);
    chk("u1 fp m0 acks", 32'(nack[1][0]), 32'd4);
    chk("u1 fp m1 acks", 32'(nack[1][1]), 32'd0);
    mode = 0;
    repeat (16) step();

    issue(1, 1'b0, 32'h4, 32'h0);
    step();
    step();
    rst_drv = 1'b1;
    step();
    rst_drv = 1'b0;
    step();
    chk("u0 abort ack", 32'(bus0.m1_ack_o), 32'd0);
    chk("u0 abort rdata", bus0.m1_rdata_o, 32'd0);
    chk("u1 abort busy", 32'(bus1.busy_o), 32'd0);
    issue(1, 1'b0, 32'h4, 32'h0);
    repeat (4) step();
    chk("u0 post-reset read", bus0.m1_rdata_o, 32'h3);
    chk("u1 post-reset read", bus1.m1_rdata_o, 32'h3);

    mode = 1;
    repeat (3000) begin
      rst_drv = ($urandom_range(0, 199) == 0);
      step();
    end
    rst_drv = 1'b0;
    mode = 0;
    repeat (12) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the peripheral register bus (GPIO, timer, UART register files).
- Master 0 is the CPU load/store port. Master 1 is the debug/DMA port.
- Serialises their accesses onto the slave bus and honours the slave's one-cycle registered read latency.
- Returns read data and a one-cycle ack to the master that owned each transfer.

Parameters:
FIXED_PRIO, 0, 0 = round-robin on simultaneous requests; 1 = master 0 always wins ties
ADDR_W, 32, address width on master and slave sides

Ports:
sys_clk  input  1  clock; all logic on rising edge
sys_reset  input  1  synchronous reset, active-high
m0_req_i  input  1  master 0 transfer request; held with command until m0_ack_o
m0_we_i  input  1  master 0: 1 = write, 0 = read
m0_addr_i  input  ADDR_W  master 0 address
m0_wdata_i  input  32  master 0 write data
m0_rdata_o  output  32  master 0 read data; valid when m0_ack_o=1 on a read, then held
m0_ack_o  output  1  master 0 transfer complete, one-cycle pulse
m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_rdata_o, m1_ack_o  same as master 0, for master 1
wr_en_o  output  1  slave write enable
wr_addr_o  output  ADDR_W  slave write address
wr_data_o  output  32  slave write data
rd_addr_o  output  ADDR_W  slave read address; slave registers it and returns data next cycle
rd_data_i  input  32  slave read data, valid the cycle after rd_addr_o is presented
busy_o  output  1  1 whenever state is not IDLE

Behaviour:
- Clocking and reset: one clock, sys_clk; reset sys_reset is synchronous and active-high.
- Reset values:
  - state = IDLE; last_grant = 1, so master 0 wins the first tie.
  - All ack_o = 0. All rdata_o = 0.
  - wr_en_o = 0; wr_addr_o, wr_data_o, rd_addr_o = 0; busy_o = 0.
- FSM states: IDLE, ACCESS, WAIT, DONE. All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - Any req high: choose winner, latch grant, go to ACCESS.
  - Only one req high: that master wins.
  - Both high, FIXED_PRIO=0: winner = ~last_grant. FIXED_PRIO=1: master 0 wins.
  - On the transition, load slave-side registers from the winner.
  - Write: wr_en_o<=1, wr_addr_o<=addr, wr_data_o<=wdata.
  - Read: rd_addr_o<=addr; wr_en_o stays 0.
  - Update last_grant<=winner.
- ACCESS (1 cycle): slave sees the command. Next edge: wr_en_o<=0, go to WAIT. rd_addr_o holds its value.
- WAIT (1 cycle):
  - rd_data_i is valid during this cycle.
  - Next edge: for a read, granted rdata_o<=rd_data_i; for a write, rdata_o is unchanged.
  - Granted ack_o<=1; go to DONE.
- DONE (1 cycle): ack high. Next edge: ack_o<=0, go to IDLE.
- Latency: req sampled in IDLE at cycle N -> ack in cycle N+3. A new transfer can begin every 4 cycles.
- Master contract:
  - Hold req, we, addr and wdata stable until ack.
  - req high in an IDLE cycle is a new request, so a master keeping req high after ack issues a back-to-back transfer.
  - Changing command fields while waiting is illegal. The arbiter ignores the change, because commands are latched on IDLE->ACCESS.
- Non-granted master: its req is ignored until the next IDLE. Its ack and rdata do not change.
- Round-robin fairness: if both masters hold req continuously, grants alternate 0,1,0,1...
- Each ack_o is high for exactly one cycle per transfer. The two acks are never high together.
- Exactly one wr_en_o pulse per write transfer. No wr_en_o pulse for reads.
- Reset mid-transfer: the next edge forces IDLE and clears ack and wr_en_o.
  - If reset asserts during ACCESS, the already-registered wr_en_o is still high for that cycle; that write is not suppressed.
  - No ack is ever produced for an aborted transfer.
- req going low before ack is illegal. The transfer still completes and acks.

Test Plan:
- Single write: m0 write addr 0x4, data 0x5 -> wr_en_o=1 for exactly one cycle with wr_addr_o=0x4 and wr_data_o=0x5; m0_ack_o pulses 3 cycles after the req cycle.
- Single read: m1 read addr 0x4 with slave returning 0xA5 the cycle after rd_addr_o -> m1_rdata_o=0xA5 with m1_ack_o; wr_en_o never asserted.
- Simultaneous requests out of reset, FIXED_PRIO=0, both req held for 4 transfers -> grant order 0,1,0,1; acks spaced 4 cycles apart and never overlapping.
- FIXED_PRIO=1, both req held -> master 0 served every transfer; m1_ack_o stays 0.
- Reset asserted in WAIT of a read -> next cycle state IDLE, no ack, rdata_o=0; the following request completes normally.
- Write then read-back via m0 (write 0x3 to 0x4, then read 0x4 from a GPIO slave model) -> m0_rdata_o=0x3.
